// File: rtl/serial_mag_comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// 2-bit relation encoding used by both the digit slice and the running verdict.
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_LT = 2'b01,
    REL_GT = 2'b10
  } rel_e;

  // One-hot {gt, eq, lt} view of a relation; the unused code maps to EQ.
  function automatic logic [2:0] rel_flags(input rel_e r);
    logic [2:0] f;
    case (r)
      REL_GT:  f = 3'b100;
      REL_EQ:  f = 3'b010;
      REL_LT:  f = 3'b001;
      default: f = 3'b010;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serial_mag_comp_slice.sv
// 2-bit combinational comparator slice: relation of digit a against digit b.
module comp2_slice
  import serial_mag_comp_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output rel_e       rel
);

  // Relation of one digit pair.
  always_comb begin
    rel = REL_EQ;
    if (a > b) begin
      rel = REL_GT;
    end else if (a < b) begin
      rel = REL_LT;
    end else begin
      rel = REL_EQ;
    end
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Serial MSB-first magnitude comparator built on comp2_slice.
// Optional feature: CMP_EARLY_EXIT_EN finishes on the first unequal digit.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] a_dig,
  input  logic [1:0] b_dig,
  output logic       in_ready,
  output logic       busy,
  output logic       out_valid,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  rel_e             rel_r;
  rel_e             rel_s;
  rel_e             slice_rel_s;
  logic             early_s;

  comp2_slice u_slice (
    .a   (a_dig),
    .b   (b_dig),
    .rel (slice_rel_s)
  );

`ifdef CMP_EARLY_EXIT_EN
  assign early_s = (rel_r == REL_EQ) && (slice_rel_s != REL_EQ);
`else
  assign early_s = 1'b0;
`endif

  // Next-state, digit counter and running relation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rel_s   = rel_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
          cnt_s   = {CNT_W{1'b0}};
          rel_s   = REL_EQ;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (in_valid) begin
          // Only the first unequal digit may change the verdict.
          if (rel_r == REL_EQ) begin
            rel_s = slice_rel_s;
          end else begin
            rel_s = rel_r;
          end
          cnt_s = cnt_r + CNT_W'(1);
          if ((cnt_r == LAST_CNT) || early_s) begin
            state_s = DONE;
          end else begin
            state_s = SCAN;
          end
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered output decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rel_r     <= REL_EQ;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rel_r     <= rel_s;
      in_ready  <= (state_s == SCAN);
      busy      <= (state_s != IDLE);
      out_valid <= (state_s == DONE);
      if (state_s == DONE) begin
        {gt, eq, lt} <= rel_flags(rel_s);
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed self-checking bench for serial_mag_comp with NUM_DIGITS=4.
module tb_serial_mag_comp;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [1:0] a_dig;
  logic [1:0] b_dig;
  logic       in_ready;
  logic       busy;
  logic       out_valid;
  logic       gt;
  logic       eq;
  logic       lt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_mag_comp #(.NUM_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .a_dig     (a_dig),
    .b_dig     (b_dig),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One comparison: start, feed digits MSB-first with an optional stall,
  // then check latency, verdict, the one-cycle pulse and the held verdict.
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int stall_at, input int stall_len, input logic [2:0] exp_flags,
                         input int exp_lat, input bit hold_start, output int start_cyc);
    int   idx;
    int   lat;
    int   stalled;
    bit   seen;
    logic acc;
    idx = 0; lat = 0; stalled = 0; seen = 1'b0;
    start    = 1'b1;
    in_valid = 1'b0;
    start_cyc = cyc;
    tick();
    start = hold_start;
    while (!seen && lat < 40) begin
      if (idx == stall_at && stalled < stall_len) begin
        in_valid = 1'b0;
        stalled++;
      end else if (idx < 4) begin
        in_valid = 1'b1;
        a_dig = 2'(a >> (6 - 2 * idx));
        b_dig = 2'(b >> (6 - 2 * idx));
      end else begin
        in_valid = 1'b0;
      end
      acc = in_ready & in_valid;
      tick();
      lat++;
      if (acc) idx++;
      if (out_valid) seen = 1'b1;
    end
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " verdict"}, {gt, eq, lt}, exp_flags);
    check_val({tag, " done ready"}, in_ready, 1'b0);
    check_val({tag, " done busy"}, busy, 1'b1);
    in_valid = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check_val({tag, " pulse"}, out_valid, 1'b0);
    check_val({tag, " idle busy"}, busy, 1'b0);
    check_val({tag, " idle ready"}, in_ready, 1'b0);
    check_val({tag, " held"}, {gt, eq, lt}, exp_flags);
  endtask

  initial begin
    int s1;
    int s2;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a_dig = 2'b00; b_dig = 2'b00;
    tick();
    tick();
    check_val("reset outs", {in_ready, busy, out_valid, gt, eq, lt}, 6'b000000);
    rst = 1'b0;
    tick();
    check_val("idle after reset", {in_ready, busy, out_valid}, 3'b000);

    run_cmp("equal", 8'b10_01_11_00, 8'b10_01_11_00, -1, 0, 3'b010, 4, 1'b0, s1);
    run_cmp("lt_d1", 8'b10_01_11_00, 8'b10_10_00_00, -1, 0, 3'b001, EARLY ? 2 : 4, 1'b0, s2);
    run_cmp("gt_last", 8'b11_00_00_01, 8'b11_00_00_00, -1, 0, 3'b100, 4, 1'b0, s2);
    run_cmp("gt_stall", 8'b11_00_00_01, 8'b11_00_00_00, 2, 3, 3'b100, 7, 1'b0, s2);
    run_cmp("lt_d0", 8'b00_11_11_11, 8'b01_00_00_00, -1, 0, 3'b001, EARLY ? 1 : 4, 1'b0, s2);
    run_cmp("gt_d0", 8'b11_00_00_00, 8'b10_11_11_11, -1, 0, 3'b100, EARLY ? 1 : 4, 1'b0, s2);
    run_cmp("start_held", 8'b01_10_11_00, 8'b01_10_10_11, -1, 0, 3'b100, EARLY ? 3 : 4, 1'b1, s2);

    // Back-to-back full-length comparisons.
    run_cmp("b2b_1", 8'b10_01_11_00, 8'b10_01_11_00, -1, 0, 3'b010, 4, 1'b0, s1);
    run_cmp("b2b_2", 8'b00_00_00_00, 8'b00_00_00_01, -1, 0, 3'b001, 4, 1'b0, s2);
    check_val("b2b period", s2 - s1, 6);

    // Abort after two digits with an asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_dig = 2'b11; b_dig = 2'b11;
    tick();
    a_dig = 2'b10; b_dig = 2'b10;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("async rst outs", {in_ready, busy, out_valid, gt, eq, lt}, 6'b000000);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("post rst quiet", {out_valid, busy, in_ready}, 3'b000);
    end
    in_valid = 1'b0;
    run_cmp("after rst", 8'b11_10_00_00, 8'b11_10_01_00, -1, 0, 3'b001, EARLY ? 3 : 4, 1'b0, s2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
